elevator_ctrl: RTL

Four-floor elevator controller that sits directly upstream of the seven-segment display stage. It latches floor requests, moves the car one floor at a time on a travel timer and holds the door open for a dwell time. It produces the `floorSel[1:0]` and `door` signals that the display stage consumes unchanged. Scheduling is SCAN-style: the car keeps its direction while requests lie ahead and reverses otherwise.

---
 rtl/elevator_pkg.sv | 33 +++
 rtl/elevator_ctrl_cycle_timer.sv | 27 ++
 rtl/elevator_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types and request-scan helpers for the four-floor elevator controller.
package elevator_pkg;

    localparam int NUM_FLOORS = 4;

    typedef logic [1:0]            floor_t;
    typedef logic [NUM_FLOORS-1:0] floorMask_t;

    typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} elev_state_t;

    function automatic logic req_above(floorMask_t pending, floor_t floor);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(floor) && pending[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic req_below(floorMask_t pending, floor_t floor);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(floor) && pending[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic floorMask_t floorOneHot(floor_t floor);
        return floorMask_t'(1) << floor;
    endfunction

endpackage

// File: rtl/elevator_ctrl_cycle_timer.sv
// Loadable down-counter shared by travel and door-dwell timing.
// done is high in the cycle the count sits at 1, so a load of N expires N edges later.
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == WIDTH'(1));

endmodule

// File: rtl/elevator_ctrl.sv
// Four-floor SCAN elevator controller: latches requests, steps the car one floor per
// travel period and holds the door for a dwell period. All outputs are registered.
//
//   state     | meaning
//   IDLE      | car parked, door closed, deciding what to do next
//   MOVING    | car travelling, floorSel steps on each travel-timer expiry
//   DOOR_OPEN | door open at floorSel, dwell timer running
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 50_000_000,
    parameter int DOOR_CYCLES   = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [1:0] floorSel,
    output logic       door,
    output logic       moving,
    output logic       dir,
    output logic [3:0] pending
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES);
    localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES);

    elev_state_t   state, stateNext;
    floor_t        floorNext, stepFloor;
    logic          doorNext, movingNext, dirNext;
    floorMask_t    pendingNext, served;
    logic          timerLoad, timerDone;
    logic [TW-1:0] timerVal;

    cycle_timer #(.WIDTH(TW)) uTimer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timerLoad),
        .load_val (timerVal),
        .done     (timerDone)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            floorSel <= '0;
            door     <= 1'b0;
            moving   <= 1'b0;
            dir      <= 1'b1;
            pending  <= '0;
        end else begin
            state    <= stateNext;
            floorSel <= floorNext;
            door     <= doorNext;
            moving   <= movingNext;
            dir      <= dirNext;
            pending  <= pendingNext;
        end
    end

    always_comb begin
        stateNext  = state;
        floorNext  = floorSel;
        doorNext   = door;
        movingNext = moving;
        dirNext    = dir;
        served     = '0;
        timerLoad  = 1'b0;
        timerVal   = TRAVEL_LOAD;
        stepFloor  = dir ? floor_t'(floorSel + 2'd1) : floor_t'(floorSel - 2'd1);

        case (state)
            IDLE: begin
                if (pending[floorSel]) begin
                    stateNext = DOOR_OPEN;
                    doorNext  = 1'b1;
                    served    = floorOneHot(floorSel);
                    timerLoad = 1'b1;
                    timerVal  = DOOR_LOAD;
                end else if (|pending) begin
                    stateNext  = MOVING;
                    movingNext = 1'b1;
                    timerLoad  = 1'b1;
                    // Nothing ahead means everything outstanding is behind us.
                    if (dir ? !req_above(pending, floorSel) : !req_below(pending, floorSel))
                        dirNext = ~dir;
                end
            end
            MOVING: begin
                if (timerDone) begin
                    floorNext = stepFloor;
                    if (pending[stepFloor]) begin
                        stateNext  = DOOR_OPEN;
                        movingNext = 1'b0;
                        doorNext   = 1'b1;
                        served     = floorOneHot(stepFloor);
                        timerLoad  = 1'b1;
                        timerVal   = DOOR_LOAD;
                    end else if (dir ? req_above(pending, stepFloor) : req_below(pending, stepFloor)) begin
                        timerLoad = 1'b1;
                    end else begin
                        stateNext  = IDLE;
                        movingNext = 1'b0;
                    end
                end
            end
            DOOR_OPEN: begin
                // A fresh call for this floor is absorbed and restarts the dwell.
                if (req[floorSel]) begin
                    served    = floorOneHot(floorSel);
                    timerLoad = 1'b1;
                    timerVal  = DOOR_LOAD;
                end else if (timerDone) begin
                    stateNext = IDLE;
                    doorNext  = 1'b0;
                end
            end
            default: begin
                stateNext  = IDLE;
                doorNext   = 1'b0;
                movingNext = 1'b0;
            end
        endcase

        pendingNext = (pending | req) & ~served;
    end

    assertNoOvershoot: assert property (@(posedge clk) disable iff (!rst_n)
        !(state == MOVING && timerDone && ((dir && floorSel == 2'd3) || (!dir && floorSel == 2'd0))));

    assertDoorMoving: assert property (@(posedge clk) disable iff (!rst_n) !(door && moving));

endmodule
